// File: rtl/demux_3_select_pkg.sv
// rtl/demux_3_select_pkg.sv - shared sizing constants and helpers for the 3-bit-select mux/demux family
package demux_3_select_pkg;

    localparam int NUM_CHANNELS  = 8;
    localparam int SELECT_WIDTH  = 3;
    localparam int PENDING_WIDTH = 4;

    function automatic logic [NUM_CHANNELS-1:0] sel_onehot(input logic [SELECT_WIDTH-1:0] sel);
        logic [NUM_CHANNELS-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // PENDING_WIDTH holds 0..NUM_CHANNELS inclusive, so the sum cannot wrap.
    function automatic logic [PENDING_WIDTH-1:0] valid_popcount(input logic [NUM_CHANNELS-1:0] v);
        logic [PENDING_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            n = n + {{(PENDING_WIDTH-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/demux_3_select_if.sv
// rtl/demux_3_select_if.sv - producer/consumer signal bundle for the 1-to-8 registered demux
import demux_3_select_pkg::*;

interface demux_3_select_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0]                     data_in;
    logic [SELECT_WIDTH-1:0]                   select;
    logic                                      in_valid;
    logic                                      in_ready;
    logic                                      enable;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   data;
    logic [NUM_CHANNELS-1:0]                   out_valid;
    logic [NUM_CHANNELS-1:0]                   out_ack;
    logic [PENDING_WIDTH-1:0]                  pending;

    modport master (
        output data_in, select, in_valid, enable, out_ack,
        input  in_ready, data, out_valid, pending
    );

    modport slave (
        input  data_in, select, in_valid, enable, out_ack,
        output in_ready, data, out_valid, pending
    );

endinterface

// File: rtl/demux_3_select_slot.sv
// rtl/demux_3_select_slot.sv - one channel holding register with valid/ack, load beats drain
module demux_channel_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ack,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    // Load checked before ack so a same-cycle drain+refill keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (ack) begin
            r_valid <= 1'b0;
        end
    end

    assign data  = r_data;
    assign valid = r_valid;

endmodule

// File: rtl/demux_3_select.sv
// rtl/demux_3_select.sv - registered 1-to-8 demux: select decode, in_ready, pending count
module demux_3_select
    import demux_3_select_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    demux_3_select_if.slave    bus
);

    logic                                    w_in_ready;
    logic [NUM_CHANNELS-1:0]                 w_load;
    logic [NUM_CHANNELS-1:0]                 w_valid;
    logic [NUM_CHANNELS-1:0]                 w_valid_next;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] w_data;
    logic [PENDING_WIDTH-1:0]                r_pending;

    // A busy target still accepts when its consumer drains it this same cycle.
    always_comb begin
        w_in_ready = !bus.enable && !rst
                     && (!w_valid[bus.select] || bus.out_ack[bus.select]);
    end

    always_comb begin
        w_load = '0;
        if (bus.in_valid && w_in_ready) begin
            w_load = sel_onehot(bus.select);
        end
    end

    always_comb begin
        w_valid_next = (w_valid & ~bus.out_ack) | w_load;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CHANNELS; g++) begin : g_slot
            demux_channel_slot #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (w_load[g]),
                .load_data (bus.data_in),
                .ack       (bus.out_ack[g]),
                .data      (w_data[g]),
                .valid     (w_valid[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= valid_popcount(w_valid_next);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.data      = w_data;
    assign bus.out_valid = w_valid;
    assign bus.pending   = r_pending;

endmodule

// File: tb/tb_demux_3_select.sv
// tb/tb_demux_3_select.sv - directed scoreboard bench for demux_3_select
module tb_demux_3_select;
    import demux_3_select_pkg::*;

    localparam int DW = 32;

    typedef struct {
        string       name;
        int          cyc;
        int          ch;      // -1: check out_valid/pending, else check data<ch>
        logic [31:0] val;
        logic [7:0]  valid;
        logic [3:0]  pend;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t q[$];

    demux_3_select_if #(.DATA_WIDTH(DW)) bus ();

    demux_3_select #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic exp_state(input string name, input logic [7:0] v, input logic [3:0] p);
        exp_t e;
        e.name = name; e.cyc = cyc; e.ch = -1; e.val = '0; e.valid = v; e.pend = p;
        q.push_back(e);
    endtask

    task automatic exp_data(input string name, input int ch, input logic [31:0] d);
        exp_t e;
        e.name = name; e.cyc = cyc; e.ch = ch; e.val = d; e.valid = '0; e.pend = '0;
        q.push_back(e);
    endtask

    task automatic chk_ready(input string name, input logic exp);
        #1;
        n_tests++;
        if (bus.in_ready !== exp) begin
            n_fail++;
            $display("FAIL %s: in_ready got %0b want %0b", name, bus.in_ready, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] sel, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.select   = sel;
        bus.data_in  = d;
    endtask

    // Monitor: pops every expectation due at this cycle and compares against the DUT.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: check missed at cycle %0d (due %0d)", e.name, cyc, e.cyc);
            end else if (e.ch < 0) begin
                if (bus.out_valid !== e.valid || bus.pending !== e.pend) begin
                    n_fail++;
                    $display("FAIL %s: out_valid/pending got %h/%0d want %h/%0d",
                             e.name, bus.out_valid, bus.pending, e.valid, e.pend);
                end
            end else begin
                if (bus.data[e.ch] !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: data%0d got %h want %h", e.name, e.ch, bus.data[e.ch], e.val);
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.in_valid = 1'b1;
        bus.select   = 3'd0;
        bus.data_in  = 32'h0;
        bus.out_ack  = 8'h00;

        // Reset and idle
        repeat (2) @(posedge clk);
        chk_ready("rst_ready", 1'b0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_state("rst_state", 8'h00, 4'd0);
        for (int i = 0; i < 8; i++) exp_data("rst_data", i, 32'h0);

        // Single routing
        offer(3'd5, 32'hDEADBEEF);
        chk_ready("single_ready", 1'b1);
        tick();
        bus.in_valid = 1'b0;
        exp_state("single_load", 8'h20, 4'd1);
        exp_data("single_data5", 5, 32'hDEADBEEF);
        bus.out_ack = 8'h20;
        tick();
        bus.out_ack = 8'h00;
        exp_state("single_drain", 8'h00, 4'd0);
        exp_data("single_data5_kept", 5, 32'hDEADBEEF);

        // Backpressure and load-wins
        offer(3'd3, 32'h1);
        tick();
        offer(3'd3, 32'h2);
        chk_ready("bp_ready_low", 1'b0);
        tick();
        exp_state("bp_state", 8'h08, 4'd1);
        exp_data("bp_data3_held", 3, 32'h1);
        bus.out_ack = 8'h08;
        chk_ready("bp_ready_ack", 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ack  = 8'h00;
        exp_state("loadwins_state", 8'h08, 4'd1);
        exp_data("loadwins_data3", 3, 32'h2);
        bus.out_ack = 8'h08;
        tick();
        bus.out_ack = 8'h00;
        exp_state("bp_drained", 8'h00, 4'd0);

        // Fill all eight channels
        for (int i = 0; i < 8; i++) begin
            offer(i[2:0], 32'h10 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        exp_state("fill_state", 8'hFF, 4'd8);
        for (int i = 0; i < 8; i++) exp_data("fill_data", i, 32'h10 + i);
        offer(3'd4, 32'h99);
        chk_ready("full_ready", 1'b0);
        tick();
        bus.in_valid = 1'b0;
        exp_state("full_state", 8'hFF, 4'd8);
        exp_data("full_data4", 4, 32'h14);
        bus.out_ack = 8'hFF;
        tick();
        bus.out_ack = 8'h00;
        exp_state("drain_all", 8'h00, 4'd0);

        // Enable gating
        offer(3'd2, 32'hA2);
        tick();
        bus.in_valid = 1'b0;
        exp_state("en_pre", 8'h04, 4'd1);
        bus.enable = 1'b1;
        offer(3'd6, 32'h66);
        chk_ready("en_ready", 1'b0);
        tick();
        exp_state("en_no_load", 8'h04, 4'd1);
        exp_data("en_data6", 6, 32'h16);
        bus.out_ack = 8'h04;
        tick();
        bus.out_ack  = 8'h00;
        bus.in_valid = 1'b0;
        bus.enable   = 1'b0;
        exp_state("en_drain", 8'h00, 4'd0);
        exp_data("en_data2", 2, 32'hA2);

        // Drain one channel while loading another, then load-wins on one channel
        offer(3'd1, 32'hB1);
        tick();
        offer(3'd0, 32'hC0);
        bus.out_ack = 8'h02;
        tick();
        bus.out_ack = 8'h00;
        exp_state("cross_state", 8'h01, 4'd1);
        exp_data("cross_data0", 0, 32'hC0);
        exp_data("cross_data1", 1, 32'hB1);
        offer(3'd0, 32'hC1);
        bus.out_ack = 8'h01;
        chk_ready("same_ready", 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ack  = 8'hFE;
        exp_state("same_state", 8'h01, 4'd1);
        exp_data("same_data0", 0, 32'hC1);
        tick();
        exp_state("stray_ack", 8'h01, 4'd1);
        bus.out_ack = 8'h01;
        tick();
        bus.out_ack = 8'h00;
        exp_state("pre_mid", 8'h00, 4'd0);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) begin
            offer(i[2:0], 32'h30 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        exp_state("mid_fill", 8'h0F, 4'd4);
        rst = 1'b1;
        offer(3'd7, 32'h77);
        chk_ready("mid_rst_ready", 1'b0);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_state("mid_rst_state", 8'h00, 4'd0);
        exp_data("mid_rst_data7", 7, 32'h0);
        exp_data("mid_rst_data0", 0, 32'h0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_queue: %0d checks left unserved, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_3_select.md
Name: demux_3_select

Overview:
Registered 1-to-8 demultiplexer, the distribution counterpart of the 3-bit-select multiplexer. It accepts one DATA_WIDTH word per cycle plus a 3-bit select, and steers the word into one of eight per-channel holding registers. Each channel has its own valid/ack handshake, and input backpressure applies only when the addressed channel is occupied. It is used on the datapath wherever one producer fans out to eight consumers, such as register-bank write distribution or peripheral write ports.

Parameters:
DATA_WIDTH, 32, width of the data word and of each channel output.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
data_in  input  DATA_WIDTH  word to distribute.
select  input  3  destination channel, 0..7.
in_valid  input  1  producer offers data_in/select this cycle.
in_ready  output  1  block accepts the offer this cycle.
enable  input  1  active-low; 0 = accepting, 1 = input side closed.
data0..data7  output  DATA_WIDTH each  channel holding registers.
out_valid  output  8  bit i = data<i> holds an unconsumed word.
out_ack  input  8  bit i = consumer i takes data<i> this cycle.
pending  output  4  number of channels with out_valid set, 0..8.

Behaviour:
- Reset (rst=1 at a clock edge): data0..data7 = 0, out_valid = 8'h00, pending = 0.
- Reset takes priority over every other event, so words held at the time of reset are discarded.
- in_ready is combinational: (enable==0) && !rst && (out_valid[select]==0 || out_ack[select]==1).
- Accept happens when in_valid && in_ready at a clock edge:
  - data<select> <= data_in
  - out_valid[select] <= 1
  - Latency: the word appears on data<select> with out_valid set one cycle after acceptance.
- Drain happens when out_valid[i] && out_ack[i] at an edge: out_valid[i] <= 0. data<i> keeps its last value; it is not cleared.
- Simultaneous drain and load on the same channel: the load wins. out_valid[i] stays 1, data<i> takes the new word, and full throughput of 1 word/cycle per channel is sustained.
- Drain of channel i and load of a different channel j in the same cycle are independent; both take effect.
- out_ack[i] while out_valid[i]==0 is ignored.
- While out_valid[i]==1 and no ack arrives, data<i> is stable, whatever happens on data_in or select.
- enable==1:
  - in_ready = 0 and no loads occur.
  - Draining continues normally, and out_valid/data outputs remain driven. There is no tri-state on this block.
- in_valid with an occupied, un-acked target: no accept. The producer must hold data_in/select until in_ready is seen.
- pending is a registered popcount of the next-state out_valid, updated on the same edge as out_valid. It is never >8 and never wraps.
- in_ready depends combinationally on select and out_ack. Producers must not derive in_valid combinationally from in_ready.

Decomposition:
- Shared header (include file) holds:
  - NUM_CHANNELS = 8
  - SELECT_WIDTH = 3
  - PENDING_WIDTH = 4
  The header is reused by mux_3_select users and the bench.
- One natural sub-module: demux_channel_slot, parameterised by DATA_WIDTH.
  - Inputs: clk, rst, load, load_data, ack.
  - Outputs: data, valid.
  - Implements the load-wins priority.
  - Eight instances sit in a generate loop.
- Top level contains the select decode (one-hot load vector), in_ready logic, and the pending popcount register.

Test Plan:
- Reset and idle: assert rst for 2 cycles with in_valid=1 -> in_ready=0 during reset; afterwards out_valid=8'h00, pending=0, data0..7=0.
- Single routing: enable=0, data_in=32'hDEADBEEF, select=5, in_valid=1 for 1 cycle -> next cycle out_valid=8'h20, data5=32'hDEADBEEF, pending=1. Then out_ack=8'h20 for 1 cycle -> out_valid=8'h00, data5 still 32'hDEADBEEF, pending=0.
- Backpressure and load-wins:
  - Load 32'h1 to select=3 with no ack, then offer 32'h2 to select=3 -> in_ready=0 and data3 stays 32'h1.
  - Raise out_ack[3] -> in_ready=1 that cycle; next cycle data3=32'h2, out_valid[3]=1, pending=1.
- Fill all: load values 0x10..0x17 into selects 0..7 on consecutive cycles with no acks -> out_valid=8'hFF, pending=8. A 9th offer to any select -> in_ready=0.
- Enable gating:
  - With channel 2 valid, set enable=1 and in_valid=1, select=6 -> in_ready=0 and channel 6 stays empty.
  - out_ack[2]=1 still clears out_valid[2] and pending decrements.
- Reset mid-operation: with out_valid=8'h0F, assert rst together with in_valid=1, select=7 -> next cycle out_valid=8'h00, data7=0, pending=0.
